// File: rtl/gtest_objection_mon_if.sv
// Objection monitor bus: bench-side stimulus (start/raise/drop/results) and monitor status outputs.
// Ports: master drives start, raise, drop, result_valid, result_pass; slave drives ch_busy,
//        total_obj, state, done, status, num_tests/passed/failed, ovf_err, unf_err.
interface gtest_objection_mon_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int TALLY_W = 16
);
  localparam int TOT_W = CNT_W + $clog2(NUM_CH) + 1;

  logic                start;
  logic [NUM_CH-1:0]   raise;
  logic [NUM_CH-1:0]   drop;
  logic                result_valid;
  logic                result_pass;

  logic [NUM_CH-1:0]   ch_busy;
  logic [TOT_W-1:0]    total_obj;
  logic [1:0]          state;
  logic                done;
  logic [1:0]          status;
  logic [TALLY_W-1:0]  num_tests;
  logic [TALLY_W-1:0]  num_passed;
  logic [TALLY_W-1:0]  num_failed;
  logic                ovf_err;
  logic                unf_err;

  modport master (
    output start, raise, drop, result_valid, result_pass,
    input  ch_busy, total_obj, state, done, status,
    input  num_tests, num_passed, num_failed, ovf_err, unf_err
  );

  modport slave (
    input  start, raise, drop, result_valid, result_pass,
    output ch_busy, total_obj, state, done, status,
    output num_tests, num_passed, num_failed, ovf_err, unf_err
  );
endinterface

// File: rtl/gtest_objection_mon.sv
// Objection tracker and end-of-test arbiter: per-channel objection counts, drain timer, result tallies.
// Latency: counts/tallies/state update one cycle after the strobe; DONE DRAIN_CYCLES edges after DRAIN entry.
// Backpressure: none; every strobe is taken each cycle (saturating counters flag ovf/unf instead of stalling).
// Ports: clk, rst_n (async active-low); bus (slave modport) carries strobes in and status out.
module gtest_objection_mon #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter int TALLY_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gtest_objection_mon_if.slave  bus
);
  localparam int TOT_W = CNT_W + $clog2(NUM_CH) + 1;
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                         r_state, w_state_nxt;
  logic [DRN_W-1:0]               r_drain_cnt, w_drain_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0]              w_busy;
  logic [TOT_W-1:0]               w_total;
  logic                           w_ovf_hit, w_unf_hit;
  logic [TALLY_W-1:0]             r_tests, r_passed, r_failed;
  logic [TALLY_W-1:0]             w_tests_nxt, w_passed_nxt, w_failed_nxt;
  logic                           r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
  logic [1:0]                     r_status, w_status_nxt;
  logic                           w_start_acc, w_result_acc;

  // Channel counters run in every state; simultaneous raise+drop cancels out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_busy    = '0;
    w_total   = '0;
    w_ovf_hit = 1'b0;
    w_unf_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
      w_total   = w_total + TOT_W'(r_cnt[i]);
      if (bus.raise[i] && !bus.drop[i]) begin
        if (r_cnt[i] == CNT_MAX) w_ovf_hit = 1'b1;
        else                     w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end else if (bus.drop[i] && !bus.raise[i]) begin
        if (r_cnt[i] == '0) w_unf_hit = 1'b1;
        else                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  // Next-state: DRAIN re-arms to RUN on any raise even before the count lands.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_total == '0) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = '0;
        end
      end
      S_DRAIN: begin
        if ((|bus.raise) || (w_total != '0)) begin
          w_state_nxt = S_RUN;
        end else if (r_drain_cnt == DRN_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drain_nxt = r_drain_cnt + 1'b1;
        end
      end
      S_DONE:  if (bus.start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start_acc  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_result_acc = bus.result_valid && ((r_state == S_RUN) || (r_state == S_DRAIN));

  // Tallies and sticky flags; an error landing on the start cycle survives the clear.
  always_comb begin
    w_tests_nxt  = r_tests;
    w_passed_nxt = r_passed;
    w_failed_nxt = r_failed;
    if (w_start_acc) begin
      w_tests_nxt  = '0;
      w_passed_nxt = '0;
      w_failed_nxt = '0;
    end else if (w_result_acc) begin
      if (r_tests != TALLY_MAX) w_tests_nxt = r_tests + 1'b1;
      if (bus.result_pass) begin
        if (r_passed != TALLY_MAX) w_passed_nxt = r_passed + 1'b1;
      end else begin
        if (r_failed != TALLY_MAX) w_failed_nxt = r_failed + 1'b1;
      end
    end
    w_ovf_nxt = (r_ovf & ~w_start_acc) | w_ovf_hit;
    w_unf_nxt = (r_unf & ~w_start_acc) | w_unf_hit;
  end

  // Status latched on DONE entry from the post-update tallies, so a result in the final cycle counts.
  always_comb begin
    w_status_nxt = r_status;
    if (w_state_nxt != S_DONE) begin
      w_status_nxt = 2'd0;
    end else if (r_state != S_DONE) begin
      if (w_failed_nxt != '0)      w_status_nxt = 2'd2;
      else if (w_passed_nxt != '0) w_status_nxt = 2'd1;
      else                         w_status_nxt = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_cnt       <= '0;
      r_tests     <= '0;
      r_passed    <= '0;
      r_failed    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_status    <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tests     <= w_tests_nxt;
      r_passed    <= w_passed_nxt;
      r_failed    <= w_failed_nxt;
      r_ovf       <= w_ovf_nxt;
      r_unf       <= w_unf_nxt;
      r_status    <= w_status_nxt;
    end
  end

  assign bus.ch_busy    = w_busy;
  assign bus.total_obj  = w_total;
  assign bus.state      = r_state;
  assign bus.done       = (r_state == S_DONE);
  assign bus.status     = r_status;
  assign bus.num_tests  = r_tests;
  assign bus.num_passed = r_passed;
  assign bus.num_failed = r_failed;
  assign bus.ovf_err    = r_ovf;
  assign bus.unf_err    = r_unf;
endmodule

// File: tb/tb_gtest_objection_mon.sv
// Bench for gtest_objection_mon: directed strobes, expected snapshots queued per edge, monitor compares.
// Latency: snapshots target the edge that consumes the strobes; done rises are checked against exact edges.
// Backpressure: n/a.
module tb_gtest_objection_mon;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 2;
  localparam int DRAIN  = 16;
  localparam int TALW   = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  gtest_objection_mon_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TALLY_W(TALW)) bus ();

  gtest_objection_mon #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN), .TALLY_W(TALW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int st, tot, busy, tests, pass, fail, ovf, unf, status;
  } snap_t;

  typedef struct {
    int cyc;
    int status;
  } done_t;

  snap_t snap_q[$];
  string nm_q[$];
  done_t done_q[$];

  function automatic void ck(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected view of the DUT right after the next rising edge.
  function automatic void exp_snap(string nm, int st, int tot, int busy, int tests, int pass,
                                   int fail, int ovf, int unf, int status);
    snap_t s;
    s.cyc = cyc + 1; s.st = st; s.tot = tot; s.busy = busy; s.tests = tests;
    s.pass = pass; s.fail = fail; s.ovf = ovf; s.unf = unf; s.status = status;
    snap_q.push_back(s);
    nm_q.push_back(nm);
  endfunction

  function automatic void exp_done(int offset, int status);
    done_t d;
    d.cyc = cyc + offset;
    d.status = status;
    done_q.push_back(d);
  endfunction

  // Monitor: compares queued snapshots on their edge and every done rise against its expected edge.
  initial begin : monitor
    logic done_prev;
    snap_t s;
    done_t d;
    string nm;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        s  = snap_q.pop_front();
        nm = nm_q.pop_front();
        if (s.cyc != cyc) begin
          checks++; failures++;
          $display("FAIL %s snapshot missed: edge %0d expected %0d", nm, cyc, s.cyc);
        end else begin
          ck({nm, ".state"},  int'(bus.state),      s.st);
          ck({nm, ".total"},  int'(bus.total_obj),  s.tot);
          ck({nm, ".busy"},   int'(bus.ch_busy),    s.busy);
          ck({nm, ".done"},   int'(bus.done),       (s.st == 3) ? 1 : 0);
          ck({nm, ".status"}, int'(bus.status),     s.status);
          ck({nm, ".tests"},  int'(bus.num_tests),  s.tests);
          ck({nm, ".passed"}, int'(bus.num_passed), s.pass);
          ck({nm, ".failed"}, int'(bus.num_failed), s.fail);
          ck({nm, ".ovf"},    int'(bus.ovf_err),    s.ovf);
          ck({nm, ".unf"},    int'(bus.unf_err),    s.unf);
        end
      end
      if (bus.done && !done_prev) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_rise unexpected at edge %0d", cyc);
        end else begin
          d = done_q.pop_front();
          ck("done_rise.edge", cyc, d.cyc);
          ck("done_rise.status", int'(bus.status), d.status);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic step(input logic st, input logic [3:0] rs, input logic [3:0] dp,
                      input logic rv, input logic rp);
    bus.start = st; bus.raise = rs; bus.drop = dp;
    bus.result_valid = rv; bus.result_pass = rp;
    @(negedge clk);
    bus.start = 1'b0; bus.raise = '0; bus.drop = '0;
    bus.result_valid = 1'b0; bus.result_pass = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.raise = '0; bus.drop = '0;
    bus.result_valid = 1'b0; bus.result_pass = 1'b0;
    @(negedge clk);
    exp_snap("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    rst_n = 1'b1;

    // 1: no objections at all -> NO-TESTS, DONE 16 edges after DRAIN entry
    exp_snap("s1_run", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_done(18, 3);
    step(1'b1, 4'b0, 4'b0, 1'b0, 1'b0);
    exp_snap("s1_drain", 2, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    idle(14);
    exp_snap("s1_drain15", 2, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    exp_snap("s1_done", 3, 0, 0, 0, 0, 0, 0, 0, 3);
    idle(1);

    // 2: ch0 x3, ch2 x1 with five passes -> PASSED
    exp_snap("s2_start", 1, 2, 4'b0101, 0, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0101, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 4'b0, 1'b1, 1'b1);
    exp_snap("s2_up", 1, 4, 4'b0101, 2, 2, 0, 0, 0, 0);
    step(1'b0, 4'b0001, 4'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    step(1'b0, 4'b0, 4'b0101, 1'b0, 1'b0);
    step(1'b0, 4'b0, 4'b0001, 1'b0, 1'b0);
    exp_snap("s2_lastdrop", 1, 0, 0, 5, 5, 0, 0, 0, 0);
    step(1'b0, 4'b0, 4'b0001, 1'b0, 1'b0);
    exp_done(17, 1);
    exp_snap("s2_drain", 2, 0, 0, 5, 5, 0, 0, 0, 0);
    idle(1);
    idle(15);
    exp_snap("s2_done", 3, 0, 0, 5, 5, 0, 0, 0, 1);
    idle(1);

    // 3: raise at quiet cycle 10 restarts the drain; a fail result lands in the first drain cycle
    exp_snap("s3_start", 1, 1, 4'b0010, 0, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0010, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 4'b0010, 1'b0, 1'b0);
    exp_snap("s3_drain", 2, 0, 0, 1, 0, 1, 0, 0, 0);
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    idle(10);
    exp_snap("s3_rerun", 1, 1, 4'b0010, 1, 0, 1, 0, 0, 0);
    step(1'b0, 4'b0010, 4'b0, 1'b0, 1'b0);
    exp_snap("s3_drop", 1, 0, 0, 1, 0, 1, 0, 0, 0);
    step(1'b0, 4'b0, 4'b0010, 1'b0, 1'b0);
    exp_done(17, 2);
    idle(16);
    exp_snap("s3_done", 3, 0, 0, 1, 0, 1, 0, 0, 2);
    idle(1);

    // 4: raise+drop at zero is harmless; lone drop at zero is sticky; results in DONE ignored
    exp_snap("s4_same", 3, 0, 0, 1, 0, 1, 0, 0, 2);
    step(1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);
    exp_snap("s4_unf", 3, 0, 0, 1, 0, 1, 0, 1, 2);
    step(1'b0, 4'b0, 4'b1000, 1'b0, 1'b0);
    idle(1);
    exp_snap("s4_sticky", 3, 0, 0, 1, 0, 1, 0, 1, 2);
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);

    // 5: saturation at 3 with CNT_W=2; 3 pass + 1 fail -> FAILED
    exp_snap("s5_start", 1, 1, 4'b0001, 0, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0001, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 4'b0, 1'b1, 1'b1);
    step(1'b0, 4'b0001, 4'b0, 1'b1, 1'b1);
    exp_snap("s5_ovf", 1, 3, 4'b0001, 3, 3, 0, 1, 0, 0);
    step(1'b0, 4'b0001, 4'b0, 1'b1, 1'b1);
    step(1'b0, 4'b0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 4'b0, 4'b0001, 1'b0, 1'b0);
    exp_snap("s5_lastdrop", 1, 0, 0, 4, 3, 1, 1, 0, 0);
    step(1'b0, 4'b0, 4'b0001, 1'b0, 1'b0);
    exp_done(17, 2);
    idle(16);
    exp_snap("s5_done", 3, 0, 0, 4, 3, 1, 1, 0, 2);
    idle(1);

    // 6: reset at drain count 2 clears everything at once; results in IDLE ignored
    exp_snap("s6_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0, 4'b0, 1'b0, 1'b0);
    exp_snap("s6_drain", 2, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    exp_snap("s6_drain2", 2, 0, 0, 2, 2, 0, 0, 0, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    ck("s6_async.state", int'(bus.state), 0);
    ck("s6_async.done", int'(bus.done), 0);
    ck("s6_async.tests", int'(bus.num_tests), 0);
    ck("s6_async.passed", int'(bus.num_passed), 0);
    exp_snap("s6_inrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    exp_snap("s6_idle_res", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    idle(3);

    while (snap_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s snapshot never compared (edge %0d)", nm_q.pop_front(), snap_q.pop_front().cyc);
    end
    while (done_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL done_rise expected at edge %0d never seen", done_q.pop_front().cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
